lstm_sample_sequencer: RTL and testbench
========================================

Name: lstm_sample_sequencer

Overview:
- Upstream/downstream controller wrapped around the LSTM+perceptron network top.
- Buffers incoming input vectors in a small FIFO and presents one vector at a time on inputVec with a single-cycle newSample pulse.
- Waits for the LSTM layer (dataReady_net), then enables the perceptron (enPerceptron) and waits for dataReadyP_net.
- Captures networkOutput into a result register with a one-cycle resultValid strobe.

Parameters:
- INPUT_SZ, 2, number of elements per input vector.
- QN, 6, integer bits of the fixed-point format.
- QM, 11, fractional bits of the fixed-point format.
- FIFO_DEPTH, 8, input FIFO entries; must be a power of two and at least 2.
- BITWIDTH, QN+QM+1, derived element width; do not override.
- INPUT_BITWIDTH, BITWIDTH*INPUT_SZ, derived; do not override.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- sampleIn  in  INPUT_BITWIDTH  input vector from the stimulus source.
- sampleValid  in  1  sampleIn is valid this cycle.
- sampleReady  out  1  FIFO not full; a sample is accepted when sampleValid && sampleReady.
- inputVec  out  INPUT_BITWIDTH  vector presented to the network.
- newSample  out  1  one-cycle start pulse to the network.
- enPerceptron  out  1  perceptron enable, level.
- dataReady_net  in  1  LSTM layer output valid (level).
- dataReadyP_net  in  1  perceptron output valid (level).
- networkOutput  in  BITWIDTH  perceptron result.
- result  out  BITWIDTH  captured result.
- resultValid  out  1  one-cycle strobe; result is updated in the same cycle.
- fifoCount  out  log2(FIFO_DEPTH)+1  current FIFO occupancy.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO is emptied; fifoCount=0, sampleReady=1.
  - FSM enters IDLE.
  - inputVec=0, newSample=0, enPerceptron=0, result=0, resultValid=0, busy=0.
  - Edge-detect registers are cleared to 0.
  - Reset mid-operation aborts the current sample and discards all queued samples.
- FIFO:
  - Synchronous write on accept; read (pop) in the cycle the FSM leaves IDLE.
  - A push and a pop in the same cycle are both honoured and fifoCount is unchanged. This includes the full case: sampleReady reflects the pre-pop count, so a push is refused when full even if a pop happens in the same cycle.
  - Write and read pointers wrap modulo FIFO_DEPTH.
  - A write attempted while full is dropped; no state change.
- Edge detect: dataReady_net and dataReadyP_net are each registered; a rising edge is input=1 && previous=0.
- FSM:
  - IDLE: if fifoCount>0, latch the head entry into inputVec, pop, and go to START.
  - START: newSample=1 for exactly this cycle; go to WAIT_L.
  - WAIT_L: on a dataReady_net rising edge, go to WAIT_P. enPerceptron rises in the cycle after this edge. This one-cycle delay is required so the network's internal enable pipeline aligns.
  - WAIT_P: enPerceptron=1. On a dataReadyP_net rising edge, register networkOutput into result, pulse resultValid for one cycle, and go to DONE.
  - DONE: enPerceptron=0 for at least this one cycle so the perceptron accumulator resets. Return to IDLE.
  - Minimum spacing between newSample pulses: 4 cycles plus the network latency.
- A dataReady_net edge seen outside WAIT_L is ignored. A dataReadyP_net edge seen outside WAIT_P is ignored.
- inputVec holds its value from START until the next IDLE→START transition.
- No arithmetic is performed on data; widths pass straight through. result takes networkOutput bit-exact.

Test Plan:
- Reset then idle: release reset with no samples → sampleReady=1, fifoCount=0, newSample never asserted, busy=0 for 50 cycles.
- Single sample, defaults: push sampleIn=0x00800_01000 (2×18-bit). Drive dataReady_net high 20 cycles after newSample, dataReadyP_net high 10 cycles later with networkOutput=0x00A00 → exactly one newSample pulse, inputVec=pushed value, enPerceptron rises 1 cycle after the dataReady_net edge, result=0x00A00, exactly one resultValid cycle, enPerceptron=0 in DONE.
- FIFO full: push 10 samples back-to-back with the network stalled → fifoCount saturates at 8, sampleReady=0, samples 9 and 10 are dropped. All 8 accepted samples are presented in FIFO order with increasing results.
- Simultaneous push/pop: FIFO holds 1 entry in IDLE and sampleValid is asserted → fifoCount stays 1 and both samples are processed in order.
- Spurious ready: pulse dataReadyP_net during WAIT_L and dataReady_net during WAIT_P → no state change and no resultValid. The correct later edges complete normally.
- Reset mid-run: assert reset during WAIT_P with 3 samples queued → all outputs return to reset values immediately. After release, no pending sample is replayed and fifoCount=0.

Source files
------------

// File: rtl/lstm_sample_sequencer_if.sv
// Handshake bundle between the sample source / LSTM network and the sample sequencer.
// The sequencer connects through the slave modport; the environment connects through master.
interface lstm_sample_sequencer_if #(
    parameter int unsigned INPUT_SZ       = 2,
    parameter int unsigned QN             = 6,
    parameter int unsigned QM             = 11,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned BITWIDTH       = QN + QM + 1,
    parameter int unsigned INPUT_BITWIDTH = BITWIDTH * INPUT_SZ,
    parameter int unsigned CNT_W          = $clog2(FIFO_DEPTH) + 1
);
    logic [INPUT_BITWIDTH-1:0] sampleIn;
    logic                      sampleValid;
    logic                      sampleReady;
    logic [INPUT_BITWIDTH-1:0] inputVec;
    logic                      newSample;
    logic                      enPerceptron;
    logic                      dataReady_net;
    logic                      dataReadyP_net;
    logic [BITWIDTH-1:0]       networkOutput;
    logic [BITWIDTH-1:0]       result;
    logic                      resultValid;
    logic [CNT_W-1:0]          fifoCount;
    logic                      busy;

    modport master (
        output sampleIn, sampleValid, dataReady_net, dataReadyP_net, networkOutput,
        input  sampleReady, inputVec, newSample, enPerceptron, result, resultValid,
               fifoCount, busy
    );

    modport slave (
        input  sampleIn, sampleValid, dataReady_net, dataReadyP_net, networkOutput,
        output sampleReady, inputVec, newSample, enPerceptron, result, resultValid,
               fifoCount, busy
    );
endinterface

// File: rtl/lstm_sample_sequencer.sv
// Queues input vectors and steps the LSTM + perceptron network through one sample at a time,
// capturing the perceptron output into a result register.
module lstm_sample_sequencer #(
    parameter int unsigned INPUT_SZ       = 2,
    parameter int unsigned QN             = 6,
    parameter int unsigned QM             = 11,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned BITWIDTH       = QN + QM + 1,
    parameter int unsigned INPUT_BITWIDTH = BITWIDTH * INPUT_SZ
) (
    input logic                    clock,
    input logic                    reset,
    lstm_sample_sequencer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [2:0] {StIdle, StStart, StWaitL, StWaitP, StDone} state_t;

    state_t                    state;
    logic [INPUT_BITWIDTH-1:0] fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wrPtr;
    logic [PTR_W-1:0]          rdPtr;
    logic [CNT_W-1:0]          count;
    logic                      full;
    logic                      push;
    logic                      pop;
    logic                      readyLPrev;
    logic                      readyPPrev;
    logic                      riseL;
    logic                      riseP;
    logic [INPUT_BITWIDTH-1:0] inputVecQ;
    logic                      newSampleQ;
    logic                      enPerceptronQ;
    logic [BITWIDTH-1:0]       resultQ;
    logic                      resultValidQ;
    logic                      busyQ;

    // Readiness uses the pre-pop count, so a full FIFO refuses a push even while popping.
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign push  = bus.sampleValid && !full;
    assign pop   = (state == StIdle) && (count != '0);
    assign riseL = bus.dataReady_net && !readyLPrev;
    assign riseP = bus.dataReadyP_net && !readyPPrev;

    always_ff @(posedge clock) begin
        if (push) begin
            fifoMem[wrPtr] <= bus.sampleIn;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            readyLPrev <= 1'b0;
            readyPPrev <= 1'b0;
        end else begin
            readyLPrev <= bus.dataReady_net;
            readyPPrev <= bus.dataReadyP_net;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= StIdle;
            inputVecQ     <= '0;
            newSampleQ    <= 1'b0;
            enPerceptronQ <= 1'b0;
            resultQ       <= '0;
            resultValidQ  <= 1'b0;
            busyQ         <= 1'b0;
        end else begin
            newSampleQ   <= 1'b0;
            resultValidQ <= 1'b0;
            case (state)
                StIdle: begin
                    if (pop) begin
                        inputVecQ  <= fifoMem[rdPtr];
                        newSampleQ <= 1'b1;
                        busyQ      <= 1'b1;
                        state      <= StStart;
                    end
                end
                StStart: begin
                    state <= StWaitL;
                end
                StWaitL: begin
                    // Enable goes high one cycle after the LSTM edge to line up the
                    // network's internal enable pipeline.
                    if (riseL) begin
                        enPerceptronQ <= 1'b1;
                        state         <= StWaitP;
                    end
                end
                StWaitP: begin
                    if (riseP) begin
                        resultQ       <= bus.networkOutput;
                        resultValidQ  <= 1'b1;
                        enPerceptronQ <= 1'b0;
                        state         <= StDone;
                    end
                end
                StDone: begin
                    // Enable stays low here so the perceptron accumulator clears.
                    busyQ <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    enPerceptronQ <= 1'b0;
                    busyQ         <= 1'b0;
                    state         <= StIdle;
                end
            endcase
        end
    end

    assign bus.sampleReady  = !full;
    assign bus.fifoCount    = count;
    assign bus.inputVec     = inputVecQ;
    assign bus.newSample    = newSampleQ;
    assign bus.enPerceptron = enPerceptronQ;
    assign bus.result       = resultQ;
    assign bus.resultValid  = resultValidQ;
    assign bus.busy         = busyQ;
endmodule

// File: tb/tb_lstm_sample_sequencer.sv
// Directed bench for lstm_sample_sequencer: the bench plays the sample source and the network.
module tb_lstm_sample_sequencer;
    localparam int BW = 18;
    localparam int IW = 36;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    lstm_sample_sequencer_if bus ();
    lstm_sample_sequencer dut (.clock(clock), .reset(reset), .bus(bus));

    int assertions = 0;
    int failures   = 0;
    int nsCount    = 0;
    int rvCount    = 0;
    logic [IW-1:0] vecLog [$];
    logic [BW-1:0] resLog [$];

    always @(negedge clock) begin
        if (bus.newSample === 1'b1) begin
            nsCount++;
            vecLog.push_back(bus.inputVec);
        end
        if (bus.resultValid === 1'b1) begin
            rvCount++;
            resLog.push_back(bus.result);
        end
    end

    function automatic logic [IW-1:0] fval(input int i);
        return {18'(i + 1), 18'(262143 - i)};
    endfunction

    task automatic push(input logic [IW-1:0] v);
        @(posedge clock);
        #1 bus.sampleIn = v;
        bus.sampleValid = 1'b1;
        @(posedge clock);
        #1 bus.sampleValid = 1'b0;
    endtask

    // Plays the network for one sample: LSTM ready dL cycles after newSample, perceptron
    // ready dP cycles after that; returns what was observed around the edges.
    task automatic serve(input logic [BW-1:0] outVal, input int dL, input int dP,
                         input bit skipWait, output bit ok, output logic enLow,
                         output logic enHigh, output logic rv, output logic [BW-1:0] res,
                         output logic enDone);
        int n = 0;
        ok = 1'b1; enLow = 1'b0; enHigh = 1'b0; rv = 1'b0; res = '0; enDone = 1'b0;
        if (!skipWait) begin
            while (bus.newSample !== 1'b1 && n < 300) begin
                @(negedge clock);
                n++;
            end
            if (bus.newSample !== 1'b1) begin
                ok = 1'b0;
                return;
            end
        end
        repeat (dL) @(posedge clock);
        #1 bus.dataReady_net = 1'b1;
        @(negedge clock);
        enLow = bus.enPerceptron;
        @(negedge clock);
        enHigh = bus.enPerceptron;
        repeat (dP - 1) @(posedge clock);
        #1 bus.networkOutput = outVal;
        bus.dataReadyP_net = 1'b1;
        @(negedge clock);
        @(negedge clock);
        rv = bus.resultValid;
        res = bus.result;
        enDone = bus.enPerceptron;
        @(posedge clock);
        #1 bus.dataReady_net = 1'b0;
        bus.dataReadyP_net = 1'b0;
    endtask

    task automatic test_reset();
        logic [62:0] gotAll, expAll;
        logic [6:0]  got, exp;
        bus.sampleIn = '0; bus.sampleValid = 1'b0; bus.dataReady_net = 1'b0;
        bus.dataReadyP_net = 1'b0; bus.networkOutput = '0;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        gotAll = {bus.inputVec, bus.newSample, bus.enPerceptron, bus.result, bus.resultValid,
                  bus.busy, bus.fifoCount, bus.sampleReady};
        expAll = {36'h0, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 4'd0, 1'b1};
        assertions++;
        if (gotAll !== expAll) begin
            failures++;
            $display("FAIL reset_outputs: got %h want %h", gotAll, expAll);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        exp = {1'b1, 4'd0, 1'b0, 1'b0};
        for (int c = 0; c < 50; c++) begin
            @(negedge clock);
            got = {bus.sampleReady, bus.fifoCount, bus.newSample, bus.busy};
            assertions++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_idle cycle %0d: got %b want %b", c, got, exp);
            end
        end
    endtask

    task automatic test_single();
        logic [IW-1:0] v;
        logic [IW-1:0] seen;
        bit ok;
        logic enLow, enHigh, rv, enDone;
        logic [BW-1:0] res;
        int ns0, rv0, vl0;
        v = {18'h00800, 18'h01000};
        ns0 = nsCount; rv0 = rvCount; vl0 = vecLog.size();
        push(v);
        serve(18'h00A00, 20, 10, 1'b0, ok, enLow, enHigh, rv, res, enDone);
        repeat (5) @(negedge clock);
        seen = (vecLog.size() > vl0) ? vecLog[vl0] : 'x;
        assertions++;
        if (ok !== 1'b1) begin failures++; $display("FAIL single_timeout: got %b want 1", ok); end
        assertions++;
        if (nsCount - ns0 !== 1) begin
            failures++; $display("FAIL single_pulses: got %0d want 1", nsCount - ns0);
        end
        assertions++;
        if (seen !== v) begin failures++; $display("FAIL single_vec: got %h want %h", seen, v); end
        assertions++;
        if ({enLow, enHigh} !== 2'b01) begin
            failures++; $display("FAIL single_en_delay: got %b want 01", {enLow, enHigh});
        end
        assertions++;
        if (rv !== 1'b1 || res !== 18'h00A00) begin
            failures++; $display("FAIL single_result: got rv=%b res=%h want rv=1 res=00a00", rv, res);
        end
        assertions++;
        if (enDone !== 1'b0) begin failures++; $display("FAIL single_en_done: got %b want 0", enDone); end
        assertions++;
        if (rvCount - rv0 !== 1) begin
            failures++; $display("FAIL single_rv_count: got %0d want 1", rvCount - rv0);
        end
        assertions++;
        if (bus.inputVec !== v || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_hold: got vec=%h busy=%b want vec=%h busy=0", bus.inputVec, bus.busy, v);
        end
    endtask

    task automatic test_fifo_full();
        logic [IW-1:0] p;
        logic [IW-1:0] seen;
        bit ok;
        logic enLow, enHigh, rv, enDone;
        logic [BW-1:0] res;
        int n, ns0, vl0;
        p = {18'h2AAAA, 18'h15555};
        ns0 = nsCount; vl0 = vecLog.size();
        push(p);
        n = 0;
        while (bus.newSample !== 1'b1 && n < 50) begin @(negedge clock); n++; end
        assertions++;
        if (bus.newSample !== 1'b1) begin failures++; $display("FAIL full_prime: got 0 want 1"); end
        @(posedge clock);
        #1;
        for (int i = 0; i < 10; i++) begin
            bus.sampleIn = fval(i);
            bus.sampleValid = 1'b1;
            @(posedge clock);
            #1;
        end
        bus.sampleValid = 1'b0;
        @(negedge clock);
        assertions++;
        if (bus.fifoCount !== 4'd8 || bus.sampleReady !== 1'b0) begin
            failures++;
            $display("FAIL full_count: got cnt=%0d rdy=%b want cnt=8 rdy=0", bus.fifoCount, bus.sampleReady);
        end
        serve(18'h00100, 3, 2, 1'b1, ok, enLow, enHigh, rv, res, enDone);
        assertions++;
        if (ok !== 1'b1 || rv !== 1'b1 || res !== 18'h00100) begin
            failures++; $display("FAIL full_prime_result: got ok=%b rv=%b res=%h want 1 1 00100", ok, rv, res);
        end
        for (int i = 0; i < 8; i++) begin
            serve(18'(257 + i), 3, 2, 1'b0, ok, enLow, enHigh, rv, res, enDone);
            assertions++;
            if (ok !== 1'b1 || rv !== 1'b1 || res !== 18'(257 + i)) begin
                failures++;
                $display("FAIL full_result %0d: got ok=%b rv=%b res=%h want 1 1 %h", i, ok, rv, res, 18'(257 + i));
            end
            seen = (vecLog.size() > vl0 + 1 + i) ? vecLog[vl0 + 1 + i] : 'x;
            assertions++;
            if (seen !== fval(i)) begin
                failures++; $display("FAIL full_order %0d: got %h want %h", i, seen, fval(i));
            end
        end
        repeat (20) @(negedge clock);
        assertions++;
        if (nsCount - ns0 !== 9 || bus.fifoCount !== 4'd0) begin
            failures++;
            $display("FAIL full_drop: got pulses=%0d cnt=%0d want 9 0", nsCount - ns0, bus.fifoCount);
        end
    endtask

    task automatic test_push_pop();
        logic [IW-1:0] a, b, seenA, seenB;
        bit ok;
        logic enLow, enHigh, rv, enDone;
        logic [BW-1:0] res;
        int vl0;
        a = {18'h01111, 18'h02222};
        b = {18'h03333, 18'h04444};
        vl0 = vecLog.size();
        @(posedge clock);
        #1 bus.sampleIn = a;
        bus.sampleValid = 1'b1;
        @(posedge clock);
        #1 bus.sampleIn = b;
        @(negedge clock);
        assertions++;
        if (bus.fifoCount !== 4'd1 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL pp_idle: got cnt=%0d busy=%b want 1 0", bus.fifoCount, bus.busy);
        end
        @(posedge clock);
        #1 bus.sampleValid = 1'b0;
        @(negedge clock);
        assertions++;
        if (bus.fifoCount !== 4'd1 || bus.newSample !== 1'b1) begin
            failures++; $display("FAIL pp_after: got cnt=%0d ns=%b want 1 1", bus.fifoCount, bus.newSample);
        end
        serve(18'h00AAA, 2, 2, 1'b0, ok, enLow, enHigh, rv, res, enDone);
        assertions++;
        if (ok !== 1'b1 || res !== 18'h00AAA) begin
            failures++; $display("FAIL pp_result_a: got ok=%b res=%h want 1 00aaa", ok, res);
        end
        serve(18'h00BBB, 2, 2, 1'b0, ok, enLow, enHigh, rv, res, enDone);
        assertions++;
        if (ok !== 1'b1 || res !== 18'h00BBB) begin
            failures++; $display("FAIL pp_result_b: got ok=%b res=%h want 1 00bbb", ok, res);
        end
        seenA = (vecLog.size() > vl0) ? vecLog[vl0] : 'x;
        seenB = (vecLog.size() > vl0 + 1) ? vecLog[vl0 + 1] : 'x;
        assertions++;
        if (seenA !== a || seenB !== b) begin
            failures++; $display("FAIL pp_order: got %h %h want %h %h", seenA, seenB, a, b);
        end
    endtask

    task automatic test_spurious();
        int n, rv0;
        rv0 = rvCount;
        push({18'h00005, 18'h00006});
        n = 0;
        while (bus.newSample !== 1'b1 && n < 50) begin @(negedge clock); n++; end
        repeat (2) @(posedge clock);
        #1 bus.dataReadyP_net = 1'b1;
        bus.networkOutput = 18'h3FFFF;
        @(posedge clock);
        #1 bus.dataReadyP_net = 1'b0;
        @(negedge clock);
        assertions++;
        if (bus.busy !== 1'b1 || bus.enPerceptron !== 1'b0 || rvCount !== rv0) begin
            failures++;
            $display("FAIL spur_p_in_wait_l: got busy=%b en=%b rv=%0d want 1 0 %0d",
                     bus.busy, bus.enPerceptron, rvCount, rv0);
        end
        @(posedge clock);
        #1 bus.dataReady_net = 1'b1;
        @(negedge clock);
        @(negedge clock);
        assertions++;
        if (bus.enPerceptron !== 1'b1) begin
            failures++; $display("FAIL spur_enter_wait_p: got en=%b want 1", bus.enPerceptron);
        end
        @(posedge clock);
        #1 bus.dataReady_net = 1'b0;
        @(posedge clock);
        #1 bus.dataReady_net = 1'b1;
        @(posedge clock);
        #1 bus.dataReady_net = 1'b0;
        @(negedge clock);
        assertions++;
        if (bus.enPerceptron !== 1'b1 || bus.busy !== 1'b1 || rvCount !== rv0) begin
            failures++;
            $display("FAIL spur_l_in_wait_p: got en=%b busy=%b rv=%0d want 1 1 %0d",
                     bus.enPerceptron, bus.busy, rvCount, rv0);
        end
        @(posedge clock);
        #1 bus.networkOutput = 18'h01234;
        bus.dataReadyP_net = 1'b1;
        @(negedge clock);
        @(negedge clock);
        assertions++;
        if (bus.resultValid !== 1'b1 || bus.result !== 18'h01234) begin
            failures++;
            $display("FAIL spur_complete: got rv=%b res=%h want 1 01234", bus.resultValid, bus.result);
        end
        @(posedge clock);
        #1 bus.dataReadyP_net = 1'b0;
        repeat (3) @(negedge clock);
        assertions++;
        if (rvCount - rv0 !== 1) begin
            failures++; $display("FAIL spur_rv_count: got %0d want 1", rvCount - rv0);
        end
    endtask

    task automatic test_reset_mid();
        logic [62:0] gotAll, expAll;
        int n, ns0;
        push({18'h00077, 18'h00088});
        n = 0;
        while (bus.newSample !== 1'b1 && n < 50) begin @(negedge clock); n++; end
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) begin
            bus.sampleIn = fval(20 + i);
            bus.sampleValid = 1'b1;
            @(posedge clock);
            #1;
        end
        bus.sampleValid = 1'b0;
        bus.dataReady_net = 1'b1;
        @(negedge clock);
        @(negedge clock);
        assertions++;
        if (bus.enPerceptron !== 1'b1 || bus.fifoCount !== 4'd3) begin
            failures++;
            $display("FAIL mid_setup: got en=%b cnt=%0d want 1 3", bus.enPerceptron, bus.fifoCount);
        end
        ns0 = nsCount;
        #2 reset = 1'b0;
        #1;
        gotAll = {bus.inputVec, bus.newSample, bus.enPerceptron, bus.result, bus.resultValid,
                  bus.busy, bus.fifoCount, bus.sampleReady};
        expAll = {36'h0, 1'b0, 1'b0, 18'h0, 1'b0, 1'b0, 4'd0, 1'b1};
        assertions++;
        if (gotAll !== expAll) begin
            failures++; $display("FAIL mid_reset_outputs: got %h want %h", gotAll, expAll);
        end
        @(posedge clock);
        #1 bus.dataReady_net = 1'b0;
        bus.networkOutput = '0;
        @(posedge clock);
        #3 reset = 1'b1;
        repeat (30) @(negedge clock);
        assertions++;
        if (nsCount !== ns0 || bus.fifoCount !== 4'd0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_no_replay: got pulses=%0d cnt=%0d busy=%b want %0d 0 0",
                     nsCount, bus.fifoCount, bus.busy, ns0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fifo_full();
        test_push_pop();
        test_spurious();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
